sprite_mover: RTL
=================

# sprite_mover

Tile-grid movement controller for one maze sprite (player or ghost). It sits directly downstream of the maze wall lookup: it drives the lookup's tile coordinates from its own registered tile position, consumes the returned 4-bit `turnable` mask ({up, down, left, right}), and advances the sprite one step per frame tick. It buffers the player's requested turn, stops at walls, and publishes pixel coordinates to the sprite renderer and tile-entry pulses to pellet logic.

## Interface
- `TILE`, 16: pixels per tile. Power of two, multiple of `STEP`.
- `STEP`, 1: pixels moved per frame tick.
- `START_X`, 2: reset tile column (1..12).
- `START_Y`, 1: reset tile row (1..12).
- `Clk`  in  1  system clock; the block's only clock.
- `Reset_n`  in  1  synchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per video frame; all motion advances only on it.
- `req_valid`  in  1  new direction request this cycle.
- `req_dir`  in  3  requested direction (`dir_t`).
- `turnable`  in  4  wall mask for (`wall_x`, `wall_y`), combinational from the lookup; bit 3 up, 2 down, 1 left, 0 right.
- `wall_x`  out  5  tile column queried = `tile_x`.
- `wall_y`  out  5  tile row queried = `tile_y`.
- `tile_x`  out  5  current tile column, 1..12.
- `tile_y`  out  5  current tile row, 1..12.
- `pix_x`  out  10  sprite pixel x.
- `pix_y`  out  10  sprite pixel y.
- `cur_dir`  out  3  current direction (`DIR_NONE` when stopped).
- `moving`  out  1  high in state MOVING.
- `tile_entered`  out  1  one-cycle pulse after `tile_x`/`tile_y` changes.

## Operation
- State: `tile_x`, `tile_y`, `offset` (0..TILE-1, distance from tile origin along `cur_dir`), `cur_dir`, `pend_dir`, FSM {STOPPED, MOVING}.
- Reset values: tile = (START_X, START_Y), offset 0, `cur_dir` and `pend_dir` = NONE, STOPPED, `tile_entered` 0, pix = ((START_X-1)*TILE, (START_Y-1)*TILE).
- Request buffer: `req_valid` loads `pend_dir` on any cycle. A later request overwrites an earlier one. A NONE request clears the buffer. The buffer clears when its direction is taken.
- On `frame_tick` with `offset == 0` (centred), decision uses the `turnable` bit of each direction:
  - `pend_dir` allowed: take it.
  - Else `cur_dir` allowed: keep it.
  - Else: `cur_dir` = NONE, go to STOPPED, keep `pend_dir`.
  - If a direction was chosen: offset <= STEP, state MOVING.
- On `frame_tick` with `offset != 0` (MOVING):
  - If `pend_dir` is the opposite of `cur_dir`: reverse immediately. Tile <= neighbour in old `cur_dir`, offset <= TILE-offset, `cur_dir` <= `pend_dir`, clear buffer, pulse `tile_entered`.
  - Else offset <= offset+STEP. On reaching TILE: offset <= 0, tile steps one in `cur_dir`, pulse `tile_entered`.
- Edge guard: a move that would take a tile coordinate outside 1..12 is treated as blocked, even if `turnable` allows it. This covers out-of-range lookup defaults of 4'b1111.
- Pixel output:
  - `pix_x` = (tile_x-1)*TILE + offset for RIGHT, minus offset for LEFT, unchanged otherwise.
  - `pix_y` follows the same rule with DOWN as + and UP as -.
  - Arithmetic is 10-bit unsigned. The edge guard ensures LEFT/UP never occur with offset>0 at tile 1.

## Timing
- `wall_x`/`wall_y` are combinational from registered tile. `turnable` is sampled in the same cycle as `frame_tick`.
- All outputs are registered and update the cycle after the tick.
- `tile_entered` is high exactly one cycle.
- Without a tick, a request changes only `pend_dir`; no output moves.
- Request and tick in the same cycle: the new request is used by that tick's decision.
- `Reset_n` low mid-move: reset values apply on the next edge regardless of `frame_tick`.

## Structure
- Package `maze_pkg`:
  - `dir_t` (NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4).
  - `MAZE_W = 12`, `MAZE_H = 12`.
  - Helper functions `dir_bit(dir_t)` (index into `turnable`) and `opposite(dir_t)`.
- The wall lookup is instantiated by the parent, not inside this block.
- One natural sub-module: `dir_arbiter`, combinational decision from (`pend_dir`, `cur_dir`, `turnable`, tile) to the next direction.

## Test plan
All scenarios use TILE=16, STEP=1 and the production maze. The parent wires the wall lookup.
- Reset at (2,1), req RIGHT, 16 ticks -> `tile_x`=3, offset 0, one `tile_entered` pulse, `pix_x`=32.
- At (3,1) moving right, req UP -> UP blocked (mask 0011), keeps RIGHT, `pend_dir` stays UP.
- Moving right into (6,1), mask 0110, no request -> STOPPED, `cur_dir` NONE, `pix_x`=80, no further motion over 20 ticks.
- At (2,1) moving right, offset 5, req LEFT + tick -> tile (3,1), offset 11, `cur_dir` LEFT, `pix_x`=21.
- Request DOWN queued while moving right; at centre of (4,1), mask 0111 -> turns DOWN, buffer clears.
- `Reset_n` low at offset 7 -> tile (2,1), offset 0, STOPPED, `pix_x`=16 next cycle.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze types and direction helpers for the sprite movement logic.
package maze_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_MOVING  = 1'b1
    } mover_state_t;

    localparam int MAZE_W = 12;
    localparam int MAZE_H = 12;

    // Index of a direction inside the {up, down, left, right} turnable mask.
    function automatic logic [1:0] dir_bit(dir_t d);
        case (d)
            DIR_UP:   return 2'd3;
            DIR_DOWN: return 2'd2;
            DIR_LEFT: return 2'd1;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic dir_t opposite(dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_NONE;
        endcase
    endfunction

    function automatic logic in_bounds(dir_t d, logic [4:0] x, logic [4:0] y);
        case (d)
            DIR_UP:    return y > 5'd1;
            DIR_DOWN:  return y < 5'(MAZE_H);
            DIR_LEFT:  return x > 5'd1;
            DIR_RIGHT: return x < 5'(MAZE_W);
            default:   return 1'b0;
        endcase
    endfunction

    // Out-of-range neighbours count as walls even when the lookup reports open.
    function automatic logic dir_allowed(dir_t d, logic [3:0] mask, logic [4:0] x, logic [4:0] y);
        return (d != DIR_NONE) && mask[dir_bit(d)] && in_bounds(d, x, y);
    endfunction

    function automatic logic [4:0] nbr_x(dir_t d, logic [4:0] x);
        case (d)
            DIR_RIGHT: return x + 5'd1;
            DIR_LEFT:  return x - 5'd1;
            default:   return x;
        endcase
    endfunction

    function automatic logic [4:0] nbr_y(dir_t d, logic [4:0] y);
        case (d)
            DIR_DOWN: return y + 5'd1;
            DIR_UP:   return y - 5'd1;
            default:  return y;
        endcase
    endfunction

endpackage

// File: rtl/sprite_mover_dir_arbiter.sv
// Chooses the direction a centred sprite leaves its tile in: pending turn first, then current heading.
module dir_arbiter
    import maze_pkg::*;
(
    input  dir_t       pend_dir,
    input  dir_t       cur_dir,
    input  logic [3:0] turnable,
    input  logic [4:0] tile_x,
    input  logic [4:0] tile_y,
    output dir_t       next_dir,
    output logic       take_pend
);

    always_comb begin
        next_dir  = DIR_NONE;
        take_pend = 1'b0;
        if (dir_allowed(pend_dir, turnable, tile_x, tile_y)) begin
            next_dir  = pend_dir;
            take_pend = 1'b1;
        end else if (dir_allowed(cur_dir, turnable, tile_x, tile_y)) begin
            next_dir = cur_dir;
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// Tile-grid movement controller for one maze sprite: buffered turns, wall stops, pixel position output.
module sprite_mover
    import maze_pkg::*;
#(
    parameter int TILE    = 16,
    parameter int STEP    = 1,
    parameter int START_X = 2,
    parameter int START_Y = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        req_valid,
    input  logic [2:0]  req_dir,
    input  logic [3:0]  turnable,
    output logic [4:0]  wall_x,
    output logic [4:0]  wall_y,
    output logic [4:0]  tile_x,
    output logic [4:0]  tile_y,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  cur_dir,
    output logic        moving,
    output logic        tile_entered
);

    localparam int OFF_W = $clog2(TILE);

    logic [4:0]       tile_x_q, tile_x_d, tile_y_q, tile_y_d;
    logic [OFF_W-1:0] offset_q, offset_d;
    logic [OFF_W:0]   off_sum;
    dir_t             cur_q, cur_d, pend_q, pend_d, pend_in, arb_dir;
    mover_state_t     state_q, state_d;
    logic             entered_q, entered_d, take_pend;
    logic [9:0]       pix_x_q, pix_x_d, pix_y_q, pix_y_d, base_x, base_y, off10;

    // A same-cycle request takes part in this cycle's decision.
    assign pend_in = req_valid ? dir_t'(req_dir) : pend_q;
    assign off_sum = {1'b0, offset_q} + (OFF_W+1)'(STEP);

    dir_arbiter u_arb (
        .pend_dir  (pend_in),
        .cur_dir   (cur_q),
        .turnable  (turnable),
        .tile_x    (tile_x_q),
        .tile_y    (tile_y_q),
        .next_dir  (arb_dir),
        .take_pend (take_pend)
    );

    always_comb begin
        tile_x_d  = tile_x_q;
        tile_y_d  = tile_y_q;
        offset_d  = offset_q;
        cur_d     = cur_q;
        pend_d    = pend_in;
        state_d   = state_q;
        entered_d = 1'b0;
        if (frame_tick) begin
            if (offset_q == '0) begin
                if (arb_dir == DIR_NONE) begin
                    cur_d   = DIR_NONE;
                    state_d = ST_STOPPED;
                end else begin
                    cur_d    = arb_dir;
                    offset_d = OFF_W'(STEP);
                    state_d  = ST_MOVING;
                    if (take_pend) pend_d = DIR_NONE;
                end
            end else if (pend_in == opposite(cur_q)) begin
                // Reversal: re-origin on the tile ahead; TILE is 2^OFF_W so TILE-offset wraps to -offset.
                tile_x_d  = nbr_x(cur_q, tile_x_q);
                tile_y_d  = nbr_y(cur_q, tile_y_q);
                offset_d  = '0 - offset_q;
                cur_d     = pend_in;
                pend_d    = DIR_NONE;
                entered_d = 1'b1;
            end else if (off_sum == (OFF_W+1)'(TILE)) begin
                tile_x_d  = nbr_x(cur_q, tile_x_q);
                tile_y_d  = nbr_y(cur_q, tile_y_q);
                offset_d  = '0;
                entered_d = 1'b1;
            end else begin
                offset_d = off_sum[OFF_W-1:0];
            end
        end

        base_x  = ({5'd0, tile_x_d} - 10'd1) * 10'(TILE);
        base_y  = ({5'd0, tile_y_d} - 10'd1) * 10'(TILE);
        off10   = 10'(offset_d);
        pix_x_d = base_x;
        pix_y_d = base_y;
        case (cur_d)
            DIR_RIGHT: pix_x_d = base_x + off10;
            DIR_LEFT:  pix_x_d = base_x - off10;
            DIR_DOWN:  pix_y_d = base_y + off10;
            DIR_UP:    pix_y_d = base_y - off10;
            default:   ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            tile_x_q  <= 5'(START_X);
            tile_y_q  <= 5'(START_Y);
            offset_q  <= '0;
            cur_q     <= DIR_NONE;
            pend_q    <= DIR_NONE;
            state_q   <= ST_STOPPED;
            entered_q <= 1'b0;
            pix_x_q   <= 10'((START_X - 1) * TILE);
            pix_y_q   <= 10'((START_Y - 1) * TILE);
        end else begin
            tile_x_q  <= tile_x_d;
            tile_y_q  <= tile_y_d;
            offset_q  <= offset_d;
            cur_q     <= cur_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
            entered_q <= entered_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
        end
    end

    assign wall_x       = tile_x_q;
    assign wall_y       = tile_y_q;
    assign tile_x       = tile_x_q;
    assign tile_y       = tile_y_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign cur_dir      = cur_q;
    assign moving       = (state_q == ST_MOVING);
    assign tile_entered = entered_q;

endmodule
